sar_search: RTL and testbench

//  Successive-approximation controller that drives the operand side of an external

---
 rtl/sar_pkg.sv | 32 +++
 rtl/sar_search.sv | 152 +++++++++++++++
 tb/tb_sar_search.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sar_pkg
// Brief    : Shared state encodings and offset-domain mapping for sar_search.
// Revision : 1.0 - initial release
// ============================================================================
package sar_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SEARCH = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_SEARCH = c_ST_SEARCH,
        ST_DONE   = c_ST_DONE
    } sar_state_t;

    localparam int c_MAP_W = 32;

    // Offset-binary <-> two's complement is a flip of the top operand bit;
    // the mapping is its own inverse and preserves ordering.
    function automatic logic [c_MAP_W-1:0] sar_offset_map(
        input logic [c_MAP_W-1:0] u,
        input int                 n,
        input bit                 sgn
    );
        return u ^ (sgn ? (c_MAP_W'(1) << (n - 1)) : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
// Module   : sar_search
// Brief    : Successive-approximation search controller driving an external
//            magnitude comparator. Optional macro SAR_EARLY_EXIT_EN ends the
//            search on the first legal equal flag.
// Revision : 1.0 - initial release
// ============================================================================
module sar_search
    import sar_pkg::*;
#(
    parameter int N      = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_gt,
    input  logic         cmp_lt,
    input  logic         cmp_eq,
    output logic [N-1:0] guess,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         found,
    output logic         err
);

    localparam int              c_KW    = $clog2(N);
    localparam logic [c_KW-1:0] c_K_TOP = c_KW'(N - 1);

    function automatic logic [N-1:0] map_n(input logic [N-1:0] u);
        return N'(sar_offset_map(c_MAP_W'(u), N, SIGNED));
    endfunction

    sar_state_t      r_state, w_state_nxt;
    logic [N-1:0]    r_acc, w_acc_nxt;
    logic [c_KW-1:0] r_k, w_k_nxt;
    logic [N-1:0]    r_guess, w_guess_nxt;
    logic [N-1:0]    r_result, w_result_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic            r_found, w_found_nxt;
    logic            r_err, w_err_nxt;

    logic            w_legal;
    logic            w_keep;
    logic            w_hit;
    logic            w_exit_early;
    logic [N-1:0]    w_acc_step;

    // Illegal flag combinations fall through as "greater than": bit dropped.
    assign w_legal    = $onehot({cmp_gt, cmp_lt, cmp_eq});
    assign w_keep     = w_legal & (cmp_lt | cmp_eq);
    assign w_hit      = w_legal & cmp_eq;
    assign w_acc_step = r_acc | (w_keep ? (N'(1) << r_k) : '0);

`ifdef SAR_EARLY_EXIT_EN
    assign w_exit_early = w_hit;
`else
    assign w_exit_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_k      <= '0;
            r_guess  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_k      <= w_k_nxt;
            r_guess  <= w_guess_nxt;
            r_result <= w_result_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_found  <= w_found_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_k_nxt      = r_k;
        w_guess_nxt  = r_guess;
        w_result_nxt = r_result;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_found_nxt  = r_found;
        w_err_nxt    = r_err;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SEARCH;
                    w_acc_nxt   = '0;
                    w_k_nxt     = c_K_TOP;
                    w_guess_nxt = map_n(N'(1) << (N - 1));
                    w_busy_nxt  = 1'b1;
                    w_found_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end

            ST_SEARCH: begin
                w_acc_nxt   = w_acc_step;
                w_found_nxt = r_found | w_hit;
                w_err_nxt   = r_err | ~w_legal;
                if (w_exit_early) begin
                    w_result_nxt = r_guess;
                    w_found_nxt  = 1'b1;
                    w_state_nxt  = ST_DONE;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                end else if (r_k == '0) begin
                    w_result_nxt = map_n(w_acc_step);
                    w_state_nxt  = ST_DONE;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_k_nxt     = r_k - c_KW'(1);
                    w_guess_nxt = map_n(w_acc_step | (N'(1) << (r_k - c_KW'(1))));
                end
            end

            // start is deliberately not sampled here; acceptance waits for IDLE.
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign guess  = r_guess;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign found  = r_found;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_search
// Brief    : Bench for sar_search: unsigned and signed instances, each wired to
//            a behavioural comparator; interval-halving reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_search;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] tgt_u, tgt_s;
    logic         force_u;
    logic [2:0]   force_val;
    logic         gt_u, lt_u, eq_u, gt_s, lt_s, eq_s;
    logic [N-1:0] guess_u, result_u, guess_s, result_s;
    logic         busy_u, done_u, found_u, err_u;
    logic         busy_s, done_s, found_s, err_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (force_u) begin
            {gt_u, lt_u, eq_u} = force_val;
        end else begin
            gt_u = guess_u > tgt_u;
            lt_u = guess_u < tgt_u;
            eq_u = guess_u == tgt_u;
        end
        gt_s = $signed(guess_s) > $signed(tgt_s);
        lt_s = $signed(guess_s) < $signed(tgt_s);
        eq_s = guess_s == tgt_s;
    end

    sar_search #(.N(N), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start),
        .cmp_gt(gt_u), .cmp_lt(lt_u), .cmp_eq(eq_u),
        .guess(guess_u), .busy(busy_u), .done(done_u),
        .result(result_u), .found(found_u), .err(err_u)
    );

    sar_search #(.N(N), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start),
        .cmp_gt(gt_s), .cmp_lt(lt_s), .cmp_eq(eq_s),
        .guess(guess_s), .busy(busy_s), .done(done_s),
        .result(result_s), .found(found_s), .err(err_s)
    );

    function automatic int msk(input int v);
        return v & ((1 << N) - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: halve the half-open interval [lo,hi) around the target; the
    // trial is the floor midpoint. fk selects the bit step whose flags are
    // corrupted (treated as greater-than, raises err).
    typedef int glist_t [N];

    function automatic void model(input int t, input bit sgn, input int fk,
                                  output glist_t g, output int res, output bit fnd,
                                  output bit er, output int steps);
        int lo, hi, m;
        bit stop;
        lo = sgn ? -(1 << (N - 1)) : 0;
        hi = lo + (1 << N);
        fnd = 0; er = 0; steps = 0; res = 0; stop = 0;
        for (int s = 0; s < N; s++) begin
            g[s] = 0;
            if (!stop) begin
                m = (lo + hi) >>> 1;
                g[s] = m;
                steps = s + 1;
                if ((N - 1 - s) == fk) begin
                    er = 1;
                    hi = m;
                end else if (m > t) begin
                    hi = m;
                end else begin
                    lo = m;
                    if (m == t) begin
                        fnd = 1;
`ifdef SAR_EARLY_EXIT_EN
                        stop = 1;
`endif
                    end
                end
            end
        end
        res = lo;
    endfunction

    task automatic run_one(input int tu, input int ts, input int fk, input logic [2:0] fv,
                           output int ru, output bit fu, output bit eu,
                           output int rs, output bit fs);
        glist_t gu, gs;
        int mru, mrs, stu, sts;
        bit mfu, meu, mfs, mes;
        model(tu, 1'b0, fk, gu, mru, mfu, meu, stu);
        model(ts, 1'b1, -1, gs, mrs, mfs, mes, sts);
        ru = -1; fu = 0; eu = 0; rs = -1; fs = 0;
        tgt_u = N'(msk(tu));
        tgt_s = N'(msk(ts));
        force_val = fv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= N + 1; c++) begin
            if (c <= stu) begin
                chk("guess_u", int'(guess_u), msk(gu[c-1]));
                chk("busy_u", int'(busy_u), 1);
                chk("done_u early", int'(done_u), 0);
            end else if (c == stu + 1) begin
                chk("done_u", int'(done_u), 1);
                chk("busy_u at done", int'(busy_u), 0);
                chk("result_u", int'(result_u), msk(mru));
                chk("found_u", int'(found_u), int'(mfu));
                chk("err_u", int'(err_u), int'(meu));
                ru = int'(result_u); fu = found_u; eu = err_u;
            end
            if (c <= sts) begin
                chk("guess_s", int'(guess_s), msk(gs[c-1]));
                chk("busy_s", int'(busy_s), 1);
            end else if (c == sts + 1) begin
                chk("done_s", int'(done_s), 1);
                chk("result_s", int'(result_s), msk(mrs));
                chk("found_s", int'(found_s), int'(mfs));
                chk("err_s", int'(err_s), 0);
                rs = int'(result_s); fs = found_s;
            end
            force_u = (c <= stu) && (fk == N - c);
            @(negedge clk);
        end
        force_u = 1'b0;
        chk("done_u after", int'(done_u), 0);
        chk("done_s after", int'(done_s), 0);
        chk("result_u held", int'(result_u), msk(mru));
    endtask

    task automatic seq_latency(input string name, input int tu, input int exp_cyc, input int exp_res);
        int c;
        tgt_u = N'(msk(tu));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!done_u && c <= N + 2) begin
            @(negedge clk);
            c++;
        end
        chk(name, c, exp_cyc);
        chk({name, " result"}, int'(result_u), exp_res);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int         tu;
        int         ts;
        int         fk;
        logic [2:0] fv;
        int         eru;
        bit         efu;
        bit         eeu;
        int         ers;
        bit         efs;
    } vec_t;

    vec_t tab [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ru, rs, tu, ts, tr, fk, pulses, prev;
        bit fu, eu, fs;
        logic [2:0] fv;
        int dcyc[$];

        tab[0] = '{11, -3, -1, 3'b000, 11, 1, 0, 13, 1};
        tab[1] = '{15,  7, -1, 3'b000, 15, 1, 0,  7, 1};
        tab[2] = '{ 0, -8, -1, 3'b000,  0, 0, 0,  8, 0};
        tab[3] = '{11,  0,  2, 3'b000, 11, 1, 1,  0, 1};
        tab[4] = '{11, -1,  1, 3'b111,  9, 0, 1, 15, 1};
        tab[5] = '{ 8,  5, -1, 3'b000,  8, 1, 0,  5, 1};

        rst = 1'b1; start = 1'b0; force_u = 1'b0; force_val = 3'b000;
        tgt_u = '0; tgt_s = '0;
        repeat (2) @(negedge clk);
        chk("reset guess_u", int'(guess_u), 0);
        chk("reset busy_u", int'(busy_u), 0);
        chk("reset done_u", int'(done_u), 0);
        chk("reset result_u", int'(result_u), 0);
        chk("reset found_u", int'(found_u), 0);
        chk("reset err_u", int'(err_u), 0);
        chk("reset guess_s", int'(guess_s), 0);
        chk("reset busy_s", int'(busy_s), 0);
        rst = 1'b0;
        @(negedge clk);

        seq_latency("latency t11", 11, N + 1, 11);
`ifdef SAR_EARLY_EXIT_EN
        seq_latency("latency t8", 8, 2, 8);
`else
        seq_latency("latency t8", 8, N + 1, 8);
`endif

        foreach (tab[i]) begin
            run_one(tab[i].tu, tab[i].ts, tab[i].fk, tab[i].fv, ru, fu, eu, rs, fs);
            chk($sformatf("tab%0d res_u", i), ru, tab[i].eru);
            chk($sformatf("tab%0d found_u", i), int'(fu), int'(tab[i].efu));
            chk($sformatf("tab%0d err_u", i), int'(eu), int'(tab[i].eeu));
            chk($sformatf("tab%0d res_s", i), rs, tab[i].ers);
            chk($sformatf("tab%0d found_s", i), int'(fs), int'(tab[i].efs));
        end

        // Reset in the middle of a search: outputs clear, no done pulse follows.
        tgt_u = 4'd11; tgt_s = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort guess_u", int'(guess_u), 0);
        chk("abort busy_u", int'(busy_u), 0);
        chk("abort result_u", int'(result_u), 0);
        chk("abort found_u", int'(found_u), 0);
        pulses = 0;
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            if (done_u || done_s) pulses++;
        end
        chk("abort no done", pulses, 0);
        run_one(0, 0, -1, 3'b000, ru, fu, eu, rs, fs);
        chk("post-abort res_u", ru, 0);

        // start held high: one search every N+2 cycles.
        tgt_u = 4'd15; tgt_s = 4'd7;
        start = 1'b1;
        for (int c = 1; c <= 3 * (N + 2) + 2; c++) begin
            @(negedge clk);
            if (done_u) begin
                dcyc.push_back(c);
                chk("b2b result", int'(result_u), 15);
            end
        end
        start = 1'b0;
        chk("b2b pulses", dcyc.size(), 3);
        if (dcyc.size() > 0) chk("b2b first done", dcyc[0], N + 1);
        prev = -1;
        foreach (dcyc[i]) begin
            if (prev >= 0) chk("b2b period", dcyc[i] - prev, N + 2);
            prev = dcyc[i];
        end
        repeat (N + 3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            tu = int'($urandom_range(0, 15));
            tr = int'($urandom_range(0, 15));
            ts = (tr >= 8) ? tr - 16 : tr;
            fk = -1;
            fv = 3'b000;
            if ($urandom_range(0, 3) == 0) begin
                fk = int'($urandom_range(0, N - 1));
                do fv = 3'($urandom_range(0, 7)); while ($onehot(fv));
            end
            run_one(tu, ts, fk, fv, ru, fu, eu, rs, fs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
